// File: rtl/ram_dump_uart.sv
// ram_dump_uart: streams a region of data RAM out over a UART 8N1 line.
// Each 16-bit word leaves as two frames, high byte first.
module ram_dump_uart #(
  parameter int ADDR_W       = 19,
  parameter int DATA_W       = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int RD_LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_q,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int CW = (CLKS_PER_BIT > 2) ?
                      $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND_HI,
    S_SEND_LO,
    S_FIN
  } state_t;

  state_t state;
  state_t state_n;

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] remaining_r;
  logic [DATA_W-1:0] word_r;
  logic [2:0]        lat_cnt;
  logic [CW-1:0]     clk_cnt;
  logic [3:0]        bit_idx;

  logic              bit_end;
  logic              frame_end;
  logic              last_word;
  logic              sending;
  logic [7:0]        cur_byte;
  logic [9:0]        frame;

  assign bit_end   = clk_cnt == CW'(CLKS_PER_BIT - 1);
  assign frame_end = bit_end && (bit_idx == 4'd9);
  assign last_word = remaining_r == ADDR_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          if (length == '0) state_n = S_FIN;
          else              state_n = S_READ;
        end
      end
      S_READ: state_n = S_WAIT;
      S_WAIT: begin
        if (lat_cnt == 3'd1) state_n = S_SEND_HI;
      end
      S_SEND_HI: begin
        if (frame_end) state_n = S_SEND_LO;
      end
      S_SEND_LO: begin
        if (frame_end) begin
          if (last_word) state_n = S_FIN;
          else           state_n = S_READ;
        end
      end
      S_FIN:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Datapath: address/length bookkeeping, read latency, bit timing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_r      <= '0;
      remaining_r <= '0;
      word_r      <= '0;
      lat_cnt     <= '0;
      clk_cnt     <= '0;
      bit_idx     <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            addr_r      <= base_addr;
            remaining_r <= length;
          end
        end
        S_READ: begin
          lat_cnt <= 3'(RD_LATENCY);
          clk_cnt <= '0;
          bit_idx <= '0;
        end
        S_WAIT: begin
          lat_cnt <= lat_cnt - 3'd1;
          if (lat_cnt == 3'd1) word_r <= mem_q;
        end
        S_SEND_HI, S_SEND_LO: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 4'd9) bit_idx <= '0;
            else                 bit_idx <= bit_idx + 4'd1;
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
          if (state == S_SEND_LO && frame_end) begin
            addr_r      <= addr_r + ADDR_W'(1);
            remaining_r <= remaining_r - ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs registered from next state so they line up with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_addr <= '0;
      mem_rd   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      mem_rd <= state_n == S_READ;
      done   <= state_n == S_FIN;
      busy   <= (state_n == S_READ)    ||
                (state_n == S_WAIT)    ||
                (state_n == S_SEND_HI) ||
                (state_n == S_SEND_LO);
      if (state_n == S_READ) begin
        if (state == S_IDLE) mem_addr <= base_addr;
        else                 mem_addr <= addr_r + ADDR_W'(1);
      end
    end
  end

  assign sending = (state == S_SEND_HI) ||
                   (state == S_SEND_LO);

  always_comb begin
    cur_byte = word_r[15:8];
    if (state == S_SEND_LO) cur_byte = word_r[7:0];
    frame = {1'b1, cur_byte, 1'b0};
    tx    = 1'b1;
    if (sending) tx = frame[bit_idx];
  end

endmodule

// File: tb/tb_ram_dump_uart.sv
// tb_ram_dump_uart: directed bench with byte/address scoreboards,
// a cycle-accurate UART decoder and a latency-2 RAM model.
module tb_ram_dump_uart;

  localparam int AW  = 19;
  localparam int CPB = 4;
  localparam int RL  = 2;
  localparam int WORD_CYC = 1 + RL + 20 * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] length = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic [15:0]   mem_q;
  logic          tx;
  logic          busy;
  logic          done;

  ram_dump_uart #(
    .ADDR_W(AW),
    .DATA_W(16),
    .CLKS_PER_BIT(CPB),
    .RD_LATENCY(RL)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .start(start),
    .base_addr(base_addr),
    .length(length),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_q(mem_q),
    .tx(tx),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // RAM model with two cycles of read latency
  logic [15:0] ram [int];
  logic [15:0] q1 = '0;
  logic [15:0] q2 = '0;
  assign mem_q = q2;

  always @(posedge clk) begin
    if (mem_rd)
      q1 <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : 16'h0;
    q2 <= q1;
  end

  logic [7:0]    exp_bytes [$];
  logic [AW-1:0] exp_addr  [$];
  int            frame_starts [$];
  int            rd_cnt = 0;
  int            done_n = 0;
  int            done_cyc = 0;

  always @(negedge clk) begin
    if (rst_n && mem_rd) begin
      rd_cnt++;
      if (exp_addr.size() == 0)
        chk("rd_unexpected", 32'(mem_addr), 32'hFFFF_FFFF);
      else
        chk("rd_addr", 32'(mem_addr), 32'(exp_addr.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (done) begin
      done_n++;
      done_cyc = cyc;
      chk("busy_at_done", 32'(busy), 32'd0);
    end
  end

  logic [9:0] dbits;
  bit         dec_on = 1'b0;
  int         dec_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      dec_on = 1'b0;
    end else if (!dec_on) begin
      if (tx === 1'b0) begin
        dec_on   = 1'b1;
        dec_cnt  = 0;
        dbits[0] = 1'b0;
        frame_starts.push_back(cyc);
      end
    end else begin
      dec_cnt++;
      if (dec_cnt % CPB == 0)
        dbits[dec_cnt / CPB] = tx;
      else
        chk("bit_hold", 32'(tx), 32'(dbits[dec_cnt / CPB]));
      if (dec_cnt == 10 * CPB - 1) begin
        chk("stop_bit", 32'(dbits[9]), 32'd1);
        if (exp_bytes.size() == 0)
          chk("byte_unexpected", 32'(dbits[8:1]), 32'h100);
        else
          chk("byte", 32'(dbits[8:1]), 32'(exp_bytes.pop_front()));
        dec_on = 1'b0;
      end
    end
  end

  task automatic kick(input logic [AW-1:0] b,
                      input logic [AW-1:0] l,
                      output int t);
    @(negedge clk);
    base_addr = b;
    length    = l;
    start     = 1'b1;
    @(posedge clk);
    #1 t = cyc - 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int n0, input int limit,
                           input string tag);
    int k = 0;
    while (done_n == n0 && k < limit) begin
      @(negedge clk);
      #1 k++;
    end
    chk(tag, 32'(done_n != n0), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, n0, f0, r0, k;

    repeat (3) @(negedge clk);
    chk("rst_tx",       32'(tx),       32'd1);
    chk("rst_busy",     32'(busy),     32'd0);
    chk("rst_done",     32'(done),     32'd0);
    chk("rst_mem_rd",   32'(mem_rd),   32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Reset partway through a data bit
    ram[0] = 16'h1234;
    exp_addr.push_back(19'h0);
    f0 = frame_starts.size();
    kick(19'h0, 19'd1, t);
    k = 0;
    while (frame_starts.size() == f0 && k < 200) begin
      @(negedge clk);
      #1 k++;
    end
    chk("midrst_frame_seen", 32'(frame_starts.size() > f0), 32'd1);
    repeat (6) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_tx",   32'(tx),   32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_idle_tx", 32'(tx), 32'd1);
    exp_addr.push_back(19'h0);
    exp_bytes.push_back(8'h12);
    exp_bytes.push_back(8'h34);
    n0 = done_n;
    kick(19'h0, 19'd1, t);
    wait_done(n0, 300, "post_rst_done");
    chk("post_rst_bytes", 32'(exp_bytes.size()), 32'd0);

    // Single word
    ram[32'h10] = 16'hA55A;
    exp_addr.push_back(19'h10);
    exp_bytes.push_back(8'hA5);
    exp_bytes.push_back(8'h5A);
    f0 = frame_starts.size();
    r0 = rd_cnt;
    n0 = done_n;
    kick(19'h10, 19'd1, t);
    chk("single_busy_t1", 32'(busy), 32'd1);
    wait_done(n0, 300, "single_done");
    chk("single_done_at", 32'(done_cyc - t), 32'd84);
    chk("single_start_at", 32'(frame_starts[f0] - t), 32'(2 + RL));
    chk("single_lo_gap",
        32'(frame_starts[f0+1] - frame_starts[f0]), 32'(10 * CPB));
    chk("single_reads", 32'(rd_cnt - r0), 32'd1);

    // Multi-word
    ram[0] = 16'h0102;
    ram[1] = 16'h0304;
    ram[2] = 16'h0506;
    for (int i = 0; i < 3; i++) exp_addr.push_back(AW'(i));
    for (int i = 1; i <= 6; i++) exp_bytes.push_back(8'(i));
    f0 = frame_starts.size();
    r0 = rd_cnt;
    n0 = done_n;
    kick(19'h0, 19'd3, t);
    wait_done(n0, 1000, "multi_done");
    chk("multi_done_at", 32'(done_cyc - t), 32'(1 + 3 * WORD_CYC));
    chk("multi_gap0",
        32'(frame_starts[f0+2] - frame_starts[f0]), 32'(WORD_CYC));
    chk("multi_gap1",
        32'(frame_starts[f0+4] - frame_starts[f0+2]), 32'(WORD_CYC));
    chk("multi_reads", 32'(rd_cnt - r0), 32'd3);
    chk("multi_bytes", 32'(exp_bytes.size()), 32'd0);

    // Address wrap-around
    ram[32'h7FFFF] = 16'hBEEF;
    ram[0] = 16'hCAFE;
    exp_addr.push_back(19'h7FFFF);
    exp_addr.push_back(19'h00000);
    exp_bytes.push_back(8'hBE);
    exp_bytes.push_back(8'hEF);
    exp_bytes.push_back(8'hCA);
    exp_bytes.push_back(8'hFE);
    r0 = rd_cnt;
    n0 = done_n;
    kick(19'h7FFFF, 19'd2, t);
    wait_done(n0, 600, "wrap_done");
    chk("wrap_done_at", 32'(done_cyc - t), 32'(1 + 2 * WORD_CYC));
    chk("wrap_reads", 32'(rd_cnt - r0), 32'd2);

    // Zero length
    f0 = frame_starts.size();
    r0 = rd_cnt;
    n0 = done_n;
    kick(19'h5, 19'd0, t);
    wait_done(n0, 10, "zero_done");
    chk("zero_done_at", 32'(done_cyc - t), 32'd1);
    repeat (5) @(negedge clk);
    chk("zero_frames", 32'(frame_starts.size() - f0), 32'd0);
    chk("zero_reads", 32'(rd_cnt - r0), 32'd0);

    // Start pulsed mid-dump is ignored
    ram[32'h20] = 16'h7E81;
    exp_addr.push_back(19'h20);
    exp_bytes.push_back(8'h7E);
    exp_bytes.push_back(8'h81);
    f0 = frame_starts.size();
    r0 = rd_cnt;
    n0 = done_n;
    kick(19'h20, 19'd1, t);
    repeat (30) @(negedge clk);
    base_addr = 19'h30;
    length    = 19'd5;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n0, 300, "ign_done");
    repeat (10) @(negedge clk);
    chk("ign_done_at", 32'(done_cyc - t), 32'd84);
    chk("ign_frames", 32'(frame_starts.size() - f0), 32'd2);
    chk("ign_reads", 32'(rd_cnt - r0), 32'd1);
    chk("ign_busy", 32'(busy), 32'd0);

    chk("sb_bytes_empty", 32'(exp_bytes.size()), 32'd0);
    chk("sb_addr_empty", 32'(exp_addr.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
